// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : values of the mode input and of the latched
//                             active mode
//   dir_t                   : counting direction used in center-aligned mode
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage : pwm_pkg

// File: rtl/pwm_cmp_ch.sv
// ---------------------------------------------------------------------------
// pwm_cmp_ch
// One compare channel. It holds the active compare value behind a shadow
// register and registers the polarity-adjusted compare result.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pwm_gen_en   run enable; while low the shadow follows ccr_in and the
//                output sits at its inactive level (pol)
//   shadow_load  one-cycle strobe: copy ccr_in into the active compare value
//                (asserted only on an update event that applies a load)
//   cnt          shared period counter value of the current cycle
//   ccr_in       requested compare value for this channel
//   pol          output polarity; 1 inverts the output
//   pwm_out      registered PWM output
// ---------------------------------------------------------------------------
module pwm_cmp_ch #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwm_gen_en,
   input  logic             shadow_load,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] ccr_in,
   input  logic             pol,
   output logic             pwm_out
);

   logic [CNT_W-1:0] ccr_act;

   // The compare uses the ccr_act value that was active during this cycle,
   // so a freshly loaded value only affects the cycle after the update event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ccr_act <= '0;
         pwm_out <= 1'b0;
      end else if (!pwm_gen_en) begin
         ccr_act <= ccr_in;
         pwm_out <= pol;
      end else begin
         if (shadow_load) begin
            ccr_act <= ccr_in;
         end
         // ccr=0 never matches (cnt>=1 in normal operation) -> inactive;
         // ccr>=arr always matches -> active.
         pwm_out <= pol ^ (cnt <= ccr_act);
      end
   end

endmodule : pwm_cmp_ch

// File: rtl/pwm_gen_mc.sv
// ---------------------------------------------------------------------------
// pwm_gen_mc
// Multi-channel PWM generator. A single period counter is shared by CH_NUM
// compare channels. Edge-aligned mode counts down from the period value to
// 1; center-aligned mode counts up to the period value and back down to 1.
// Period and compare values are shadowed and only change on an update
// event (period boundary), so outputs never glitch.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pwm_gen_en   run enable; low = stopped, outputs at inactive level
//   mode         0 = edge-aligned, 1 = center-aligned (taken while stopped)
//   load         one-cycle request to transfer counter_arr/counter_ccr into
//                the active registers at the next update event
//   counter_arr  requested period (reload) value
//   counter_ccr  requested compare values, channel i at [i*CNT_W +: CNT_W]
//   pol          per-channel output polarity; 1 inverts that output
//   pwm_out      registered PWM outputs
//   period_end   one-cycle pulse on each update event
// ---------------------------------------------------------------------------
module pwm_gen_mc
   import pwm_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    pwm_gen_en,
   input  logic                    mode,
   input  logic                    load,
   input  logic [CNT_W-1:0]        counter_arr,
   input  logic [CH_NUM*CNT_W-1:0] counter_ccr,
   input  logic [CH_NUM-1:0]       pol,
   output logic [CH_NUM-1:0]       pwm_out,
   output logic                    period_end
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] arr_act;
   logic [CNT_W-1:0] arr_next;
   dir_t             dir;
   dir_t             dir_nxt;
   logic             mode_act;
   logic             upd_pending;
   logic             upd_evt;
   logic             apply_now;

   // Next-count / update-event decode for the running case. The disabled
   // case overrides everything in the register block below.
   // NOTE: every signal driven here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      upd_evt = 1'b0;
      cnt_nxt = cnt;
      dir_nxt = dir;

      if (mode_act == MODE_EDGE) begin
         if (cnt <= ONE) begin
            upd_evt = 1'b1;
         end else begin
            cnt_nxt = cnt - ONE;
         end
      end else if (arr_act <= ONE) begin
         // Degenerate center period: park at 1, boundary every cycle.
         upd_evt = 1'b1;
         cnt_nxt = ONE;
         dir_nxt = DIR_UP;
      end else if (dir == DIR_UP) begin
         if (cnt >= arr_act) begin
            dir_nxt = DIR_DOWN;
            cnt_nxt = cnt - ONE;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end else begin
         if (cnt <= ONE) begin
            // Bottom turn-around: 1 is shown once, restart the climb at 2.
            upd_evt = 1'b1;
            dir_nxt = DIR_UP;
            cnt_nxt = TWO;
         end else begin
            cnt_nxt = cnt - ONE;
         end
      end

      // A load arriving on the boundary cycle itself is honoured at once.
      apply_now = upd_evt & (upd_pending | load);
      arr_next  = apply_now ? counter_arr : arr_act;

      if ((mode_act == MODE_EDGE) && upd_evt) begin
         cnt_nxt = arr_next;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every register samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= ONE;
         dir         <= DIR_UP;
         mode_act    <= MODE_EDGE;
         arr_act     <= '0;
         upd_pending <= 1'b0;
         period_end  <= 1'b0;
      end else if (!pwm_gen_en) begin
         // Stopped: shadows track the inputs and any pending load is dropped.
         arr_act     <= counter_arr;
         mode_act    <= mode;
         upd_pending <= 1'b0;
         dir         <= DIR_UP;
         period_end  <= 1'b0;
         cnt         <= (mode == MODE_EDGE) ? counter_arr : ONE;
      end else begin
         cnt        <= cnt_nxt;
         dir        <= dir_nxt;
         period_end <= upd_evt;
         if (apply_now) begin
            arr_act     <= counter_arr;
            upd_pending <= 1'b0;
         end else if (load) begin
            upd_pending <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      pwm_cmp_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .pwm_gen_en  (pwm_gen_en),
         .shadow_load (apply_now),
         .cnt         (cnt),
         .ccr_in      (counter_ccr[i*CNT_W +: CNT_W]),
         .pol         (pol[i]),
         .pwm_out     (pwm_out[i])
      );
   end

endmodule : pwm_gen_mc

// File: tb/tb_pwm_gen_mc.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen_mc
// Self-checking bench for pwm_gen_mc (4 channels, 16-bit counter).
// Directed sequences check the documented scenarios against closed-form
// expectations; a random phase checks against a queue-based reference that
// lists the counter values of each period.
// ---------------------------------------------------------------------------
module tb_pwm_gen_mc;

   localparam int CH = 4;
   localparam int W  = 16;

   logic          clk;
   logic          reset_n;
   logic          pwm_gen_en;
   logic          mode;
   logic          load;
   logic [W-1:0]  counter_arr;
   logic [CH*W-1:0] counter_ccr;
   logic [CH-1:0] pol;
   logic [CH-1:0] pwm_out;
   logic          period_end;

   int tests  = 0;
   int failed = 0;

   pwm_gen_mc #(
      .CH_NUM (CH),
      .CNT_W  (W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pwm_gen_en  (pwm_gen_en),
      .mode        (mode),
      .load        (load),
      .counter_arr (counter_arr),
      .counter_ccr (counter_ccr),
      .pol         (pol),
      .pwm_out     (pwm_out),
      .period_end  (period_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned m_cur;
   int unsigned m_rest[$];
   int unsigned m_arr;
   int unsigned m_ccr[CH];
   bit          m_mode;
   bit          m_pend;
   logic [CH-1:0] m_out;
   logic        m_pe;

   // Build the list of counter values of one period; the last entry is the
   // boundary cycle. 'first' selects the start-from-1 climb after enabling.
   function automatic void seq_period(int unsigned arr, bit center, bit first);
      int unsigned q[$];
      q = {};
      if (!center) begin
         if (arr <= 1) q.push_back(arr);
         else for (int v = int'(arr); v >= 1; v--) q.push_back(v);
      end else begin
         if (arr <= 1) q.push_back(1);
         else begin
            for (int v = (first ? 1 : 2); v <= int'(arr); v++) q.push_back(v);
            for (int v = int'(arr) - 1; v >= 1; v--) q.push_back(v);
         end
      end
      m_cur  = q.pop_front();
      m_rest = q;
   endfunction

   function automatic void model_reset();
      m_cur  = 1;
      m_rest = {};
      m_arr  = 0;
      for (int i = 0; i < CH; i++) m_ccr[i] = 0;
      m_mode = 1'b0;
      m_pend = 1'b0;
      m_out  = '0;
      m_pe   = 1'b0;
   endfunction

   function automatic void model_step();
      bit now;
      if (!reset_n) begin
         model_reset();
      end else if (!pwm_gen_en) begin
         m_arr = counter_arr;
         for (int i = 0; i < CH; i++) m_ccr[i] = counter_ccr[i*W +: W];
         m_mode = mode;
         m_pend = 1'b0;
         m_out  = pol;
         m_pe   = 1'b0;
         seq_period(counter_arr, mode, 1'b1);
      end else begin
         for (int i = 0; i < CH; i++) m_out[i] = pol[i] ^ (m_cur <= m_ccr[i]);
         if (m_rest.size() == 0) begin
            m_pe = 1'b1;
            now  = m_pend || load;
            if (now) begin
               m_arr = counter_arr;
               for (int i = 0; i < CH; i++) m_ccr[i] = counter_ccr[i*W +: W];
               m_pend = 1'b0;
            end
            seq_period(m_arr, m_mode, 1'b0);
         end else begin
            m_pe  = 1'b0;
            m_cur = m_rest.pop_front();
            if (load) m_pend = 1'b1;
         end
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model sees the pre-edge inputs; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ccr(input int c0, input int c1, input int c2, input int c3);
      counter_ccr = {W'(c3), W'(c2), W'(c1), W'(c0)};
   endtask

   typedef struct {
      logic          en;
      logic [CH-1:0] pol;
      int            ccr_all;
      logic [CH-1:0] exp_out;
      logic          exp_pe;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int unsigned ecnt;
      int          ph;
      int          eccr;
      bit          center;

      vecs[0] = '{1'b0, 4'b0101,  0, 4'b0101, 1'b0};
      vecs[1] = '{1'b1, 4'b0101,  0, 4'b0101, 1'b0};
      vecs[2] = '{1'b1, 4'b0101,  0, 4'b0101, 1'b0};
      vecs[3] = '{1'b0, 4'b0101, 10, 4'b0101, 1'b0};
      vecs[4] = '{1'b1, 4'b0101, 10, 4'b1010, 1'b0};
      vecs[5] = '{1'b1, 4'b0101, 10, 4'b1010, 1'b0};
      vecs[6] = '{1'b1, 4'b1111, 10, 4'b0000, 1'b0};

      reset_n = 1'b0; pwm_gen_en = 1'b0; mode = 1'b0; load = 1'b0;
      counter_arr = '0; counter_ccr = '0; pol = '0;
      model_reset();
      tick(); tick();
      check("reset_out", 32'(pwm_out), 32'h0);
      check("reset_pe", 32'(period_end), 32'h0);
      reset_n = 1'b1;

      // Edge, arr=10, ccr0=3: high on cnt 3,2,1; boundary at cnt=1.
      counter_arr = 10; set_ccr(3, 0, 0, 0); pol = '0;
      tick();
      pwm_gen_en = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         check("edge_out0", 32'(pwm_out[0]), 32'(((n - 1) % 10) >= 7));
         check("edge_pe", 32'(period_end), 32'((n % 10) == 0));
      end

      // Center, arr=6, ccr0=2, ccr1=6: 1..6..1 then 2..6..1 repeating.
      pwm_gen_en = 1'b0; mode = 1'b1; counter_arr = 6; set_ccr(2, 6, 0, 0);
      tick();
      pwm_gen_en = 1'b1;
      for (int n = 1; n <= 25; n++) begin
         int unsigned tbl[10];
         tbl = '{5, 4, 3, 2, 1, 2, 3, 4, 5, 6};
         tick();
         if (n <= 6) ecnt = n;
         else ecnt = tbl[(n - 7) % 10];
         check("ctr_out", 32'(pwm_out[1:0]), {30'b0, 1'b1, ecnt <= 2});
         check("ctr_pe", 32'(period_end), 32'((n > 1) && (ecnt == 1)));
      end

      // Shadow update: ccr0 4->6 with load mid-period, later 6->2 without load.
      pwm_gen_en = 1'b0; mode = 1'b0; counter_arr = 8; set_ccr(4, 0, 0, 0);
      tick();
      pwm_gen_en = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         load = (n == 3);
         if (n == 3) set_ccr(6, 0, 0, 0);
         if (n == 12) set_ccr(2, 0, 0, 0);
         tick();
         ph   = (n - 1) % 8;
         ecnt = 8 - ph;
         eccr = (n <= 8) ? 4 : 6;
         check("shadow_out0", 32'(pwm_out[0]), 32'(ecnt <= eccr));
         check("shadow_pe", 32'(period_end), 32'(ph == 7));
      end
      load = 1'b0;

      // Load coinciding with the boundary: arr=5 applies to the next period;
      // a later arr change without load has no effect.
      pwm_gen_en = 1'b0; counter_arr = 8; set_ccr(2, 0, 0, 0);
      tick();
      pwm_gen_en = 1'b1;
      for (int n = 1; n <= 23; n++) begin
         load = (n == 8);
         if (n == 8) counter_arr = 5;
         if (n == 10) counter_arr = 7;
         tick();
         ecnt = (n <= 8) ? 9 - n : 5 - ((n - 9) % 5);
         check("simul_out0", 32'(pwm_out[0]), 32'(ecnt <= 2));
         check("simul_pe", 32'(period_end), 32'(ecnt == 1));
      end
      load = 1'b0;

      // Polarity / disable table, edge mode with arr=10.
      counter_arr = 10;
      foreach (vecs[k]) begin
         pwm_gen_en = vecs[k].en;
         pol        = vecs[k].pol;
         set_ccr(vecs[k].ccr_all, vecs[k].ccr_all, vecs[k].ccr_all, vecs[k].ccr_all);
         tick();
         check($sformatf("tbl%0d_out", k), 32'(pwm_out), 32'(vecs[k].exp_out));
         check($sformatf("tbl%0d_pe", k), 32'(period_end), 32'(vecs[k].exp_pe));
      end

      // Reset in the middle of a center-mode run, on a boundary-pulse cycle.
      pwm_gen_en = 1'b0; mode = 1'b1; counter_arr = 6; set_ccr(0, 0, 0, 0); pol = 4'b1111;
      tick();
      pwm_gen_en = 1'b1;
      for (int n = 1; n <= 11; n++) tick();
      check("prerst_out", 32'(pwm_out), 32'hf);
      check("prerst_pe", 32'(period_end), 32'h1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_async_out", 32'(pwm_out), 32'h0);
      check("rst_async_pe", 32'(period_end), 32'h0);
      pwm_gen_en = 1'b0; pol = 4'b0000; set_ccr(1, 2, 3, 6);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("rst_hold_out", 32'({period_end, pwm_out}), 32'h0);
      end
      reset_n = 1'b1;
      tick();
      check("rst_dis_out", 32'(pwm_out), 32'h0);
      pwm_gen_en = 1'b1;
      begin
         logic [CH-1:0] exp_seq[5];
         exp_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1000};
         for (int n = 0; n < 5; n++) begin
            tick();
            check("rst_restart_out", 32'(pwm_out), 32'(exp_seq[n]));
         end
      end

      // Randomised run against the period-list reference model.
      for (int n = 0; n < 4000; n++) begin
         reset_n    = ($urandom_range(0, 499) != 0);
         pwm_gen_en = ($urandom_range(0, 39) != 0);
         mode       = $urandom_range(0, 1) != 0;
         center     = pwm_gen_en ? m_mode : mode;
         counter_arr = W'(center ? $urandom_range(2, 12) : $urandom_range(0, 12));
         load       = ($urandom_range(0, 7) == 0);
         set_ccr($urandom_range(0, 14), $urandom_range(0, 14),
                 $urandom_range(0, 14), $urandom_range(0, 14));
         if ($urandom_range(0, 49) == 0) pol = CH'($urandom_range(0, 15));
         tick();
         check("rand", 32'({period_end, pwm_out}), 32'({m_pe, m_out}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_pwm_gen_mc
